tagged_arbitrated_fifo_bank: RTL
================================

# tagged_arbitrated_fifo_bank

Bank of NUM_FIFOS independent FIFOs with a tagged push port and one shared registered output port. It replaces the abstract-arbiter harness with a concrete round-robin arbiter and adds optional full-FIFO push redirection that reports the tag of the FIFO actually written. Sits between multi-source producers and a single downstream consumer with ready/valid backpressure.

## Interface
- NUM_FIFOS, 4, channel count, ≥2
- WIDTH, 8, data width in bits
- DEPTH, 4, entries per FIFO, power of two, ≥2
- REDIRECT, 1, 1 = push to a full FIFO goes to the next non-full FIFO; 0 = push is refused
- TAGWIDTH, $clog2(NUM_FIFOS), tag width, derived, not overridden
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- push  in  1  push request
- push_sel  in  TAGWIDTH  requested FIFO; values ≥ NUM_FIFOS are refused
- data_in  in  WIDTH  push data
- push_ack  out  1  push accepted this cycle (combinational)
- push_tag  out  TAGWIDTH  FIFO written when push_ack=1, else 0
- reqs  in  NUM_FIFOS  per-FIFO pop request
- out_ready  in  1  consumer accepts out_data
- gnt  out  NUM_FIFOS  one-hot pop grant this cycle, or 0
- out_valid  out  1  out_data/out_tag valid
- out_data  out  WIDTH  popped word
- out_tag  out  TAGWIDTH  source FIFO of out_data
- full  out  NUM_FIFOS  per-FIFO full
- empty  out  NUM_FIFOS  per-FIFO empty

## Operation
- Push target: push_sel if that FIFO is not full; else if REDIRECT=1, first non-full FIFO searching push_sel+1, push_sel+2, … modulo NUM_FIFOS; else none.
- push_ack = push & target exists; write happens on the clk edge ending the cycle; push_tag = target. No target → word dropped, push_ack=0, no state change.
- Full/empty evaluated on start-of-cycle state: a full FIFO refuses push even if popped the same cycle; an empty FIFO is not eligible even if pushed the same cycle (no bypass).
- Eligible = reqs & ~empty. Pop enabled when eligible≠0 and (!out_valid | out_ready).
- Arbiter: round-robin, priority starts at last_grant+1 modulo NUM_FIFOS; gnt = one-hot of the winner when pop enabled, else 0. last_grant updates only on a pop.
- Fairness: a continuously eligible FIFO is granted within NUM_FIFOS pops.
- Output register: on pop, out_data ← head of granted FIFO, out_tag ← index, out_valid ← 1; else if out_ready, out_valid ← 0; out_data/out_tag hold.
- Per-FIFO order preserved. With REDIRECT=1, per-push_sel order is not guaranteed; consumers use out_tag.

## Timing
- Reset (async assert, sync-safe release): all FIFOs empty (empty=all 1s, full=0), last_grant=NUM_FIFOS-1 (FIFO 0 highest priority first), out_valid=0, out_data=0, out_tag=0, gnt=0.
- Reset mid-operation discards all stored words and any held output word.
- push_ack, push_tag, gnt: combinational from inputs and current state, same cycle.
- Minimum latency: word pushed in cycle t → eligible in t+1 → out_valid in t+2.
- Throughput: one push and one pop per cycle sustained.
- Pointer wrap: read/write pointers carry one extra bit; full when indices match and wrap bits differ.

## Structure
- Shared package tagged_fifo_pkg: TAGWIDTH derivation, redirect-search function (next non-full index from a start tag), parameter-legality checks.
- Sub-module rr_arbiter (params N; ports clk, rst_n, req, advance, gnt) holds last_grant; FIFO storage is a generate loop in the top.

## Test plan
- Reset, then push_sel=2 data 0xA5 with reqs=4'b0100, out_ready=1 → push_ack=1, push_tag=2; gnt=4'b0100 one cycle later; out_valid=1, out_data=0xA5, out_tag=2 two cycles after push.
- REDIRECT=1, fill FIFO 1 (4 words), push_sel=1 data 0x33 → push_ack=1, push_tag=2; all four full → push_ack=0, contents unchanged. REDIRECT=0, FIFO 1 full → push_ack=0.
- Each FIFO holds 2 words, reqs=4'b1111, out_ready=1 → out_tag sequence 0,1,2,3,0,1,2,3.
- out_valid=1 with out_ready=0 for 3 cycles → gnt=0, out_data stable; out_ready=1 → next grant same cycle.
- Full FIFO 0, pop and push_sel=0 same cycle → pop occurs, push refused (REDIRECT=0); empty FIFO 3, push_sel=3 with reqs[3]=1 → gnt[3]=0 that cycle.
- Assert rst_n low with 3 words stored and out_valid=1 → out_valid=0, empty=4'b1111 immediately, before next clk edge.

Source files
------------

// File: rtl/tagged_fifo_pkg.sv
// Shared definitions for the tagged FIFO bank: tag sizing, legality checks
// and the full-FIFO redirect search.
package tagged_fifo_pkg;

  // Upper bound on channel count; sizes the full vector handed to the search.
  localparam int unsigned MAX_FIFOS = 32;

  // Bits needed to name one of n FIFOs.
  function automatic int unsigned tag_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Legal configurations: 2..MAX_FIFOS channels, power-of-two depth of at least 2.
  function automatic bit params_legal(input int unsigned n, input int unsigned depth);
    return (n >= 2) && (n <= MAX_FIFOS) && (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // Returns the FIFO a push lands in, or n when no FIFO can take it.
  // The requested FIFO wins if not full; otherwise, with redirect, the first
  // non-full FIFO searching start+1, start+2, ... modulo n.
  function automatic int unsigned next_non_full(input logic [MAX_FIFOS-1:0] full,
                                                input int unsigned start,
                                                input int unsigned n,
                                                input bit redirect);
    int unsigned result;
    int unsigned idx;
    result = n;
    if (start < n) begin
      if (!full[5'(start)]) begin
        result = start;
      end else if (redirect) begin
        for (int unsigned k = 1; k < MAX_FIFOS; k++) begin
          idx = (start + k) % n;
          if ((k < n) && (result == n) && !full[5'(idx)]) result = idx;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester after the last winner has top priority.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] last_grant;
  logic [IW-1:0] winner;
  logic          found;

  // Pick the first requester at or after last_grant+1, wrapping modulo N.
  always_comb begin
    int unsigned idx;
    winner = last_grant;
    found  = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last_grant) + k) % N;
      if (!found && req[IW'(idx)]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
    gnt = '0;
    if (advance && found) gnt[winner] = 1'b1;
  end

  // Priority pointer moves only when a grant is actually consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IW'(N - 1);
    end else if (advance && found) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/tagged_arbitrated_fifo_bank.sv
// Bank of independent FIFOs with a tagged (optionally redirecting) push port
// and a single round-robin arbitrated, registered output port.
module tagged_arbitrated_fifo_bank
  import tagged_fifo_pkg::*;
#(
  parameter  int unsigned NUM_FIFOS = 4,
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned DEPTH     = 4,
  parameter  bit          REDIRECT  = 1'b1,
  localparam int unsigned TAGWIDTH  = tag_width(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [TAGWIDTH-1:0]  push_sel,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 push_ack,
  output logic [TAGWIDTH-1:0]  push_tag,
  input  logic [NUM_FIFOS-1:0] reqs,
  input  logic                 out_ready,
  output logic [NUM_FIFOS-1:0] gnt,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [TAGWIDTH-1:0]  out_tag,
  output logic [NUM_FIFOS-1:0] full,
  output logic [NUM_FIFOS-1:0] empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (!params_legal(NUM_FIFOS, DEPTH)) begin : g_bad_params
    $error("tagged_arbitrated_fifo_bank: illegal NUM_FIFOS/DEPTH");
  end

  logic [MAX_FIFOS-1:0] full_pad;
  int unsigned          target;
  logic [NUM_FIFOS-1:0] eligible;
  logic                 pop_en;
  logic [WIDTH-1:0]     head [NUM_FIFOS];
  logic [WIDTH-1:0]     pop_data;
  logic [TAGWIDTH-1:0]  pop_tag;

  // Resolve the push destination from start-of-cycle full flags.
  always_comb begin
    full_pad                = '0;
    full_pad[NUM_FIFOS-1:0] = full;
    target   = next_non_full(full_pad, 32'(push_sel), NUM_FIFOS, REDIRECT);
    push_ack = push && (target < NUM_FIFOS);
    push_tag = push_ack ? TAGWIDTH'(target) : '0;
  end

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_fifo
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign wr_en    = push_ack && (push_tag == TAGWIDTH'(i));
    assign rd_en    = gnt[i];
    assign full[i]  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty[i] = (wr_ptr == rd_ptr);
    assign head[i]  = mem[rd_ptr[AW-1:0]];

    // Pointers carry a wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
    end

    // Storage array; contents are meaningless while the FIFO is empty.
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  assign eligible = reqs & ~empty;
  assign pop_en   = (|eligible) && (!out_valid || out_ready);

  rr_arbiter #(
    .N(NUM_FIFOS)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (eligible),
    .advance(pop_en),
    .gnt    (gnt)
  );

  // Select the granted FIFO's head word and index.
  always_comb begin
    pop_data = '0;
    pop_tag  = '0;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      if (gnt[i]) begin
        pop_data = head[i];
        pop_tag  = TAGWIDTH'(i);
      end
    end
  end

  // Output register: load on pop, drop valid once the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (pop_en) begin
      out_valid <= 1'b1;
      out_data  <= pop_data;
      out_tag   <= pop_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
